// File: rtl/hp_mul_seq.sv
// hp_mul_seq: sequential IEEE-754 binary16 multiplier, round-to-nearest-even.
//
// One operation is in flight at a time. An operand pair is accepted in IDLE and
// unpacked the next cycle. If either operand is NaN, infinity or zero, the result
// is resolved right there and the block goes straight to DONE. Otherwise the two
// 11-bit significands are multiplied by an 11-step shift-add loop. The product is
// then normalized (including denormalization into the subnormal range) and rounded.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid (only looked at in IDLE)
//   in_ready   block can accept (IDLE and not in reset)
//   a, b       FP16 operands, captured on accept
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes the result
//   result     FP16 product
//   invalid, overflow, underflow, inexact   IEEE exception flags, valid with result
module hp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [15:0]       a_reg, b_reg;
    logic              sign_reg;
    logic signed [7:0] exp_reg;
    logic [21:0]       mcand_reg;
    logic [10:0]       mplier_reg;
    logic [21:0]       product_reg;
    logic [3:0]        count_reg;
    logic [10:0]       sig_reg;
    logic              guard_reg, sticky_reg, tiny_reg;
    logic [15:0]       result_reg;
    logic              invalid_reg, overflow_reg, underflow_reg, inexact_reg;

    // ------------------------------------------------------------------
    // Operand classification and unpacking (index 0 = a, 1 = b)
    // ------------------------------------------------------------------
    logic [1:0][15:0] opnd;
    logic [1:0]       is_nan, is_snan, is_inf, is_zero;
    logic [1:0][10:0] sig_norm;
    logic [1:0][7:0]  exp_eff;

    assign opnd[0] = a_reg;
    assign opnd[1] = b_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [4:0]  ex;
            logic [9:0]  fr;
            logic [10:0] raw;
            logic [3:0]  lzc;

            assign ex  = opnd[gi][14:10];
            assign fr  = opnd[gi][9:0];
            assign raw = {(ex != 5'd0), fr};

            assign is_nan[gi]  = (ex == 5'h1F) && (fr != 10'd0);
            assign is_snan[gi] = (ex == 5'h1F) && (fr != 10'd0) && !fr[9];
            assign is_inf[gi]  = (ex == 5'h1F) && (fr == 10'd0);
            assign is_zero[gi] = (ex == 5'd0) && (fr == 10'd0);

            // Leading-zero count of the 11-bit significand; the highest set bit wins.
            always_comb begin
                lzc = 4'd0;
                for (int i = 0; i < 11; i++) begin
                    if (raw[i]) begin
                        lzc = 4'(10 - i);
                    end
                end
            end

            // Normals have lzc=0, so the shift only moves subnormals up to bit 10.
            assign sig_norm[gi] = raw << lzc;
            assign exp_eff[gi]  = (ex == 5'd0) ? (8'd1 - {4'd0, lzc}) : {3'd0, ex};
        end
    endgenerate

    logic        sign_xor;
    logic        special;
    logic [15:0] spec_result;
    logic        spec_invalid;

    assign sign_xor = a_reg[15] ^ b_reg[15];
    assign special  = (|is_nan) | (|is_inf) | (|is_zero);

    always_comb begin
        spec_result  = 16'h0000;
        spec_invalid = 1'b0;
        if (|is_nan) begin
            spec_result  = 16'h7E00;
            spec_invalid = |is_snan;
        end else if ((is_inf[0] && is_zero[1]) || (is_zero[0] && is_inf[1])) begin
            spec_result  = 16'h7E00;
            spec_invalid = 1'b1;
        end else if (|is_inf) begin
            spec_result = {sign_xor, 15'h7C00};
        end else begin
            spec_result = {sign_xor, 15'h0000};
        end
    end

    // ------------------------------------------------------------------
    // Normalization of the raw product
    // ------------------------------------------------------------------
    logic [7:0]  norm_exp;
    logic [10:0] norm_sig, den_sig;
    logic        norm_guard, norm_sticky, den_guard, den_sticky;
    logic        norm_tiny;
    logic [7:0]  den_shift;
    logic [23:0] den_wide;

    always_comb begin
        if (product_reg[21]) begin
            norm_exp    = exp_reg + 8'd1;
            norm_sig    = product_reg[21:11];
            norm_guard  = product_reg[10];
            norm_sticky = |product_reg[9:0];
        end else begin
            norm_exp    = exp_reg;
            norm_sig    = product_reg[20:10];
            norm_guard  = product_reg[9];
            norm_sticky = |product_reg[8:0];
        end

        norm_tiny = norm_exp[7] || (norm_exp == 8'd0);
        den_shift = 8'd1 - norm_exp;
        den_wide  = 24'd0;

        if (!norm_tiny) begin
            den_sig    = norm_sig;
            den_guard  = norm_guard;
            den_sticky = norm_sticky;
        end else if (den_shift >= 8'd12) begin
            // Every significand bit lands below the guard position.
            den_sig    = 11'd0;
            den_guard  = 1'b0;
            den_sticky = norm_sticky | norm_guard | (|norm_sig);
        end else begin
            // {sig, guard} shifted right, with room below to catch the lost bits.
            den_wide   = {norm_sig, norm_guard, 12'd0} >> den_shift[3:0];
            den_sig    = den_wide[23:13];
            den_guard  = den_wide[12];
            den_sticky = norm_sticky | (|den_wide[11:0]);
        end
    end

    // ------------------------------------------------------------------
    // Rounding (RNE) and final packing
    // ------------------------------------------------------------------
    logic        round_inc;
    logic [11:0] round_sum;
    logic [7:0]  round_exp;
    logic [9:0]  round_frac;
    logic        round_ovf;
    logic [15:0] round_result;

    always_comb begin
        round_inc = guard_reg & (sticky_reg | sig_reg[0]);
        round_sum = {1'b0, sig_reg} + {11'd0, round_inc};
        if (tiny_reg) begin
            // A subnormal that rounds up to 0x400 becomes the smallest normal.
            round_exp  = {7'd0, round_sum[10]};
            round_frac = round_sum[9:0];
        end else begin
            round_exp  = exp_reg + {7'd0, round_sum[11]};
            round_frac = round_sum[11] ? round_sum[10:1] : round_sum[9:0];
        end
        round_ovf    = !tiny_reg && (round_exp >= 8'd31);
        round_result = round_ovf ? {sign_reg, 5'h1F, 10'd0}
                                 : {sign_reg, round_exp[4:0], round_frac};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = UNPACK;
                end
            end
            UNPACK: state_next = special ? DONE : MUL;
            MUL: begin
                if (count_reg == 4'd10) begin
                    state_next = NORM;
                end
            end
            NORM:  state_next = ROUND;
            ROUND: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg         <= 16'd0;
            b_reg         <= 16'd0;
            sign_reg      <= 1'b0;
            exp_reg       <= 8'sd0;
            mcand_reg     <= 22'd0;
            mplier_reg    <= 11'd0;
            product_reg   <= 22'd0;
            count_reg     <= 4'd0;
            sig_reg       <= 11'd0;
            guard_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            tiny_reg      <= 1'b0;
            result_reg    <= 16'd0;
            invalid_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            inexact_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                UNPACK: begin
                    sign_reg <= sign_xor;
                    if (special) begin
                        result_reg    <= spec_result;
                        invalid_reg   <= spec_invalid;
                        overflow_reg  <= 1'b0;
                        underflow_reg <= 1'b0;
                        inexact_reg   <= 1'b0;
                    end else begin
                        mcand_reg   <= {11'd0, sig_norm[0]};
                        mplier_reg  <= sig_norm[1];
                        product_reg <= 22'd0;
                        count_reg   <= 4'd0;
                        exp_reg     <= exp_eff[0] + exp_eff[1] - 8'd15;
                    end
                end
                MUL: begin
                    // Multiplier consumed LSB first; multiplicand walks left in step.
                    if (mplier_reg[0]) begin
                        product_reg <= product_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    if (count_reg != 4'd10) begin
                        count_reg <= count_reg + 4'd1;
                    end
                end
                NORM: begin
                    exp_reg    <= norm_exp;
                    sig_reg    <= den_sig;
                    guard_reg  <= den_guard;
                    sticky_reg <= den_sticky;
                    tiny_reg   <= norm_tiny;
                end
                ROUND: begin
                    result_reg    <= round_result;
                    invalid_reg   <= 1'b0;
                    overflow_reg  <= round_ovf;
                    inexact_reg   <= guard_reg | sticky_reg | round_ovf;
                    underflow_reg <= tiny_reg & (guard_reg | sticky_reg);
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = result_reg;
    assign invalid   = invalid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign inexact   = inexact_reg;

endmodule

// File: tb/tb_hp_mul_seq.sv
// Scoreboard bench for hp_mul_seq. The driver issues directed operand pairs and
// queues the hand-computed result, the flags and the cycle in which out_valid must
// first appear. The monitor pops an entry whenever the DUT presents a result,
// optionally holds out_ready low, and then completes the handshake.
module tb_hp_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        invalid, overflow, underflow, inexact;

    hp_mul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (op_a),
        .b        (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .invalid  (invalid),
        .overflow (overflow),
        .underflow(underflow),
        .inexact  (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;   // {invalid, overflow, underflow, inexact}
        int          ready_edge;
        int          hold;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {invalid, overflow, underflow, inexact};
    endfunction

    // Wait (bounded) for in_ready at a falling edge.
    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [15:0] a_v, input logic [15:0] b_v,
                         input logic [15:0] res, input logic [3:0] flg,
                         input bit special, input int hold);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        op_a     = a_v;
        op_b     = b_v;
        in_valid = 1'b1;
        e.a          = a_v;
        e.b          = b_v;
        e.res        = res;
        e.flg        = flg;
        e.ready_edge = cyc + 1 + (special ? 1 : 14);
        e.hold       = hold;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: checks every presented result against the head of the queue.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    $display("txn a=%04h b=%04h result=%04h flags=%04b expected=%04h/%04b cycle=%0d",
                             e.a, e.b, result, flags_now(), e.res, e.flg, cyc);
                    check("latency", 32'(cyc), 32'(e.ready_edge));
                    check("result", 32'(result), 32'(e.res));
                    check("flags", 32'(flags_now()), 32'(e.flg));
                    for (int k = 0; k < e.hold; k++) begin
                        @(negedge clk);
                        check("hold_out_valid", 32'(out_valid), 32'd1);
                        check("hold_result", 32'(result), 32'(e.res));
                        check("hold_flags", 32'(flags_now()), 32'(e.flg));
                        check("hold_in_ready", 32'(in_ready), 32'd0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    check("post_xfer_out_valid", 32'(out_valid), 32'd0);
                    check("post_xfer_in_ready", 32'(in_ready), 32'd1);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].ready_edge) begin
                check("out_valid_timeout", 32'(out_valid), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // Driver
    initial begin
        bit ok;
        rst      = 1'b1;
        in_valid = 1'b0;
        op_a     = 16'h0000;
        op_b     = 16'h0000;

        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'h0);
        check("reset_flags", 32'(flags_now()), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_in_ready", 32'(in_ready), 32'd1);

        // Finite path
        issue(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 1'b0, 0);
        issue(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 1'b0, 0);
        issue(16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 1'b0, 0);
        issue(16'hC000, 16'h3800, 16'hBC00, 4'b0000, 1'b0, 0);
        issue(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 1'b0, 0);
        issue(16'h0001, 16'h3800, 16'h0000, 4'b0011, 1'b0, 0);
        issue(16'h0200, 16'h4000, 16'h0400, 4'b0000, 1'b0, 0);
        issue(16'h0001, 16'h3C00, 16'h0001, 4'b0000, 1'b0, 0);
        issue(16'h3C01, 16'h3E01, 16'h3E03, 4'b0001, 1'b0, 0);
        // Special cases
        issue(16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 1'b1, 0);
        issue(16'h7C01, 16'h3C00, 16'h7E00, 4'b1000, 1'b1, 0);
        issue(16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, 1'b1, 0);
        issue(16'hFC00, 16'h4000, 16'hFC00, 4'b0000, 1'b1, 0);
        issue(16'h8000, 16'h3C00, 16'h8000, 4'b0000, 1'b1, 0);
        // Back-pressure: hold out_ready low for 5 cycles
        issue(16'h4000, 16'h4000, 16'h4400, 4'b0000, 1'b0, 5);
        issue(16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 1'b1, 5);

        // Reset in the middle of MUL discards the operation
        wait_ready(ok);
        if (ok) begin
            op_a     = 16'h3C00;
            op_b     = 16'h3C00;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("mid_reset_out_valid", 32'(out_valid), 32'd0);
            check("mid_reset_result", 32'(result), 32'h0);
            check("mid_reset_flags", 32'(flags_now()), 32'h0);
            check("mid_reset_in_ready", 32'(in_ready), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("mid_reset_release_in_ready", 32'(in_ready), 32'd1);
            check("mid_reset_release_out_valid", 32'(out_valid), 32'd0);
        end
        issue(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 1'b0, 0);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
